// File: rtl/uart_echo_fifo.sv
// Buffered UART echo engine: FIFO between uart_rx and uart_tx with per-byte case transform.
// Optional CR -> CR LF expansion is built when UART_ECHO_CRLF_EN is defined.
module uart_echo_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           rxData,
    input  logic                            rxDataValid,
    input  logic                            txBusy,
    output logic [DATA_WIDTH-1:0]           txData,
    output logic                            txDataValid,
    input  logic [1:0]                      mode,
    input  logic                            clr_ovf,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] MODE_UPPER = 2'b01;
    localparam logic [1:0] MODE_LOWER = 2'b10;
    localparam logic [1:0] MODE_MUTE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
`ifdef UART_ECHO_CRLF_EN
        , S_ISSUE_LF
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr, level;
    logic [CW-1:0]           wait_cnt;
    logic [DATA_WIDTH-1:0]   head, issue_data, tx_hold;
    logic                    empty, full, pop, tx_valid;
    logic                    push_req, accept, drop;

    // Case rules only touch 7-bit ASCII letters; wider frames with upper bits set pass through.
    function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [1:0] m);
        logic [DATA_WIDTH-1:0] r;
        r = d;
        if ((d >> 8) == '0) begin
            if (m == MODE_UPPER && d[7:0] >= 8'h61 && d[7:0] <= 8'h7A)
                r = d - DATA_WIDTH'(8'h20);
            else if (m == MODE_LOWER && d[7:0] >= 8'h41 && d[7:0] <= 8'h5A)
                r = d + DATA_WIDTH'(8'h20);
        end
        return r;
    endfunction

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (level == '0);
    assign full     = (level == PW'(FIFO_DEPTH));
    assign head     = mem[rd_ptr[AW-1:0]];
    assign push_req = rxDataValid && (mode != MODE_MUTE);
    assign accept   = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // NOTE: storage has no reset; pointers alone define valid contents, so the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr[AW-1:0]] <= rxData;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
            tx_hold  <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_q == S_WAIT_BUSY) ? wait_cnt + 1'b1 : '0;
            if (tx_valid)
                tx_hold <= issue_data;
        end
    end

`ifdef UART_ECHO_CRLF_EN
    logic lf_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lf_pend_q <= 1'b0;
        else if (state_q == S_ISSUE && issue_data == DATA_WIDTH'(8'h0D))
            lf_pend_q <= 1'b1;
        else if (state_q == S_ISSUE_LF)
            lf_pend_q <= 1'b0;
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tx_valid   = 1'b0;
        pop        = 1'b0;
        issue_data = xform(head, mode);
        case (state_q)
            S_IDLE: begin
`ifdef UART_ECHO_CRLF_EN
                if (lf_pend_q && !txBusy)
                    state_d = S_ISSUE_LF;
                else
`endif
                if (!empty && !txBusy)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tx_valid = 1'b1;
                pop      = 1'b1;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (txBusy)
                    state_d = S_WAIT_DONE;
                else if (wait_cnt == CW'(BUSY_TIMEOUT - 1))
                    state_d = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!txBusy)
                    state_d = S_IDLE;
            end
`ifdef UART_ECHO_CRLF_EN
            S_ISSUE_LF: begin
                tx_valid   = 1'b1;
                issue_data = DATA_WIDTH'(8'h0A);
                state_d    = S_WAIT_BUSY;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // txData shows the live frame during an issue and the last issued frame otherwise.
    assign txData      = tx_valid ? issue_data : tx_hold;
    assign txDataValid = tx_valid;
    assign fifo_level  = level;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo with a simple uart_tx busy model.
// Expected CR handling follows UART_ECHO_CRLF_EN, matching the RTL build.
module tb_uart_echo_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rxData = 8'h00;
    logic       rxDataValid = 1'b0;
    logic       txBusy;
    logic [7:0] txData;
    logic       txDataValid;
    logic [1:0] mode = 2'b00;
    logic       clr_ovf = 1'b0;
    logic [4:0] fifo_level;
    logic       overflow;

    uart_echo_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .BUSY_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxData      (rxData),
        .rxDataValid (rxDataValid),
        .txBusy      (txBusy),
        .txData      (txData),
        .txDataValid (txDataValid),
        .mode        (mode),
        .clr_ovf     (clr_ovf),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for busy_len cycles after each strobe, or forced high.
    logic busy_force = 1'b0;
    int   busy_len   = 10;
    int   busy_cnt   = 0;
    assign txBusy = busy_force || (busy_cnt != 0);

    always @(negedge clk) begin
        if (rst)
            busy_cnt <= 0;
        else if (txDataValid)
            busy_cnt <= busy_len;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_strobes = 0;
    logic [7:0] sb[$];
    int         strobe_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [7:0] ref_xform(input logic [7:0] b, input logic [1:0] m);
        case (m)
            2'b01:   return (b inside {[8'h61:8'h7A]}) ? b - 8'h20 : b;
            2'b10:   return (b inside {[8'h41:8'h5A]}) ? b + 8'h20 : b;
            default: return b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && txDataValid) begin
            n_strobes++;
            strobe_q.push_back(cyc);
            if (sb.size() == 0)
                check("spurious_strobe", 32'(sb.size()), 1);
            else
                check("echo", txData, sb.pop_front());
        end
    end

    task automatic push(input logic [7:0] b, input bit accepted);
        @(negedge clk);
        rxData      = b;
        rxDataValid = 1'b1;
        if (accepted && mode != 2'b11)
            sb.push_back(ref_xform(b, mode));
    endtask

    task automatic rx_off();
        @(negedge clk);
        rxDataValid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        wait_cycles(30);
        check(tag, 32'(sb.size()), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int s0;
        logic [7:0] str [3];
        str[0] = 8'h61; str[1] = 8'h5A; str[2] = 8'h31;

        // Reset state
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);
        check("rst_valid", txDataValid, 0);
        check("rst_data", txData, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);

        // Burst echo with latency check
        mode = 2'b00;
        busy_len = 10;
        strobe_q.delete();
        push(8'h41, 1);
        t0 = cyc;
        push(8'h62, 1);
        push(8'h7A, 1);
        rx_off();
        drain("burst_drain");
        check("burst_count", 32'(strobe_q.size()), 3);
        check("burst_latency", strobe_q[0] - t0, 2);
        check("tx_hold", txData, 8'h7A);

        // Transforms
        for (int m = 1; m <= 2; m++) begin
            mode = 2'(m);
            for (int i = 0; i < 3; i++) push(str[i], 1);
            rx_off();
            drain("xform_drain");
        end

        mode = 2'b11;
        s0 = n_strobes;
        push(8'h78, 1);
        rx_off();
        wait_cycles(10);
        check("mute_no_strobe", n_strobes, s0);
        check("mute_level", fifo_level, 0);
        check("mute_ovf", overflow, 0);
        mode = 2'b00;

        // Overflow: no pops while busy is held high
        busy_force = 1'b1;
        for (int i = 0; i < 18; i++) push(8'h30 + 8'(i), i < 16);
        rx_off();
        check("ovf_level", fifo_level, 16);
        check("ovf_flag", overflow, 1);
        busy_len = 2;
        s0 = n_strobes;
        busy_force = 1'b0;
        drain("ovf_drain");
        check("ovf_drain_count", n_strobes - s0, 16);
        check("ovf_sticky", overflow, 1);
        @(negedge clk) clr_ovf = 1'b1;
        @(negedge clk) clr_ovf = 1'b0;
        check("ovf_clear", overflow, 0);

        // Full FIFO with a push landing in the ISSUE cycle
        busy_force = 1'b1;
        busy_len = 20;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1);
        rx_off();
        check("full_level", fifo_level, 16);
        @(negedge clk) busy_force = 1'b0;
        push(8'hA5, 1);
        check("full_pop_align", txDataValid, 1);
        rx_off();
        check("full_pop_level", fifo_level, 16);
        check("full_pop_ovf", overflow, 0);
        drain("full_pop_drain");

        // Reset while waiting for the transmitter to finish
        busy_len = 20;
        push(8'h11, 1);
        push(8'h22, 0);
        rx_off();
        wait_cycles(4);
        check("pre_rst_level", fifo_level, 1);
        rst = 1'b1;
        wait_cycles(2);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_valid", txDataValid, 0);
        check("mid_rst_data", txData, 0);
        rst = 1'b0;
        s0 = n_strobes;
        wait_cycles(40);
        check("post_rst_no_strobe", n_strobes, s0);
        check("post_rst_level", fifo_level, 0);

        // Busy never rises: timeout returns to IDLE
        busy_len = 0;
        strobe_q.delete();
        push(8'h55, 1);
        push(8'h66, 1);
        rx_off();
        drain("timeout_drain");
        check("timeout_count", 32'(strobe_q.size()), 2);
        check("timeout_spacing", strobe_q[1] - strobe_q[0], 6);

        // Carriage return handling
        busy_len = 3;
        strobe_q.delete();
        push(8'h0D, 1);
`ifdef UART_ECHO_CRLF_EN
        sb.push_back(8'h0A);
`endif
        rx_off();
        drain("cr_drain");
`ifdef UART_ECHO_CRLF_EN
        check("cr_count", 32'(strobe_q.size()), 2);
`else
        check("cr_count", 32'(strobe_q.size()), 1);
`endif
        check("cr_level", fifo_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
